// File: rtl/dsp_sys_arr_pkg.sv
// dsp_sys_arr_pkg: shared types and helpers for the systolic-array stream scheduler
package dsp_sys_arr_pkg;
  localparam int SA_WORD_W = 32;
  typedef logic [SA_WORD_W-1:0] word_t;
  typedef enum logic [2:0] {IDLE, PUSH, WAIT, POP, DONE} sched_state_t;
  // Push beat p walks the shared dimension from the top: n = n_dim-1-p/ch, chunk = p%ch.
  function automatic int beat_addr(input int p, input int n_dim, input int ch);
    return (n_dim - 1 - p / ch) * ch + p % ch;
  endfunction
endpackage

// File: rtl/sa_beat_fifo.sv
// sa_beat_fifo: 2-deep show-ahead beat buffer between operand banks and the array input.
//   clk_i/rst_i : clock, sync active-high reset (empties the buffer)
//   push_i/data_i : write a beat (ignored when full)
//   pop_i : drop the head beat (ignored when empty)
//   data_o : head beat, full_o/empty_o/cnt_o : occupancy
module sa_beat_fifo #(
  parameter int W = 256
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   cnt_o
);
  logic [W-1:0] mem_q [2];
  logic wr_q, rd_q;
  logic [1:0] cnt_q;
  logic push_ok, pop_ok;
  assign full_o  = cnt_q == 2'd2;
  assign empty_o = cnt_q == 2'd0;
  assign cnt_o   = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      wr_q  <= wr_q ^ push_ok;
      rd_q  <= rd_q ^ pop_ok;
      cnt_q <= cnt_q + 2'(push_ok) - 2'(pop_ok);
    end
  end
endmodule

// File: rtl/sa_stream_sched.sv
// sa_stream_sched: feeds the systolic array input stream from A/B banks and drains results to C bank.
//   CLK/RST : clock, sync active-high reset (aborts a job without done)
//   start/busy/done : job handshake; cycles : busy-cycle count of the last job
//   a_/b_rd_* : operand bank reads (data one cycle after strobe)
//   in_stream/in_valid/in_ready : beats to the array, lanes 2i = A word i, 2i+1 = B word i
//   out_stream/out_valid/out_ready : results from the array
//   c_wr_* : result bank writes (pass-through of out_stream)
//   stall_cycles : present only with SA_SCHED_STALL_CNT_EN defined
module sa_stream_sched import dsp_sys_arr_pkg::*; #(
  parameter  int BW      = 8,
  parameter  int M       = 4,
  parameter  int N       = 4,
  parameter  int K       = M,
  parameter  int WORD_W  = SA_WORD_W,
  localparam int CH      = M / (BW / 2),
  localparam int P_BEATS = N * CH,
  localparam int Q_BEATS = (K / 2) * CH,
  localparam int AW      = (P_BEATS > 1) ? $clog2(P_BEATS) : 1,
  localparam int CW      = (Q_BEATS > 1) ? $clog2(Q_BEATS) : 1,
  localparam int HW      = (BW / 2) * WORD_W,
  localparam int LW      = BW * WORD_W
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          a_rd_en,
  output logic [AW-1:0] a_rd_addr,
  input  logic [HW-1:0] a_rd_data,
  output logic          b_rd_en,
  output logic [AW-1:0] b_rd_addr,
  input  logic [HW-1:0] b_rd_data,
  output logic [LW-1:0] in_stream,
  output logic          in_valid,
  input  logic          in_ready,
  input  logic [LW-1:0] out_stream,
  input  logic          out_valid,
  output logic          out_ready,
  output logic          c_wr_en,
  output logic [CW-1:0] c_wr_addr,
  output logic [LW-1:0] c_wr_data,
  output logic [31:0]   cycles
`ifdef SA_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]   stall_cycles
`endif
);
  typedef logic [AW:0] rcnt_t;
  localparam rcnt_t P_TOT = rcnt_t'(P_BEATS);
  localparam rcnt_t P_LAST = rcnt_t'(P_BEATS - 1);
  localparam logic [CW-1:0] Q_LAST = CW'(Q_BEATS - 1);
  sched_state_t state_q, state_d;
  rcnt_t rd_cnt_q, acc_cnt_q;
  logic [CW-1:0] wr_cnt_q;
  logic inflight_q;
  logic [31:0] cycles_q;
  logic [LW-1:0] f_din, f_head;
  logic f_full, f_empty;
  logic [1:0] f_cnt;
  logic [2:0] credit;
  logic start_acc, issue, pop, wr, last_wr;
  logic [AW-1:0] addr;
  for (genvar i = 0; i < BW / 2; i++) begin : g_lane
    assign f_din[2*i*WORD_W +: WORD_W]     = a_rd_data[i*WORD_W +: WORD_W];
    assign f_din[(2*i+1)*WORD_W +: WORD_W] = b_rd_data[i*WORD_W +: WORD_W];
  end
  sa_beat_fifo #(.W(LW)) u_fifo (
    .clk_i  (CLK),
    .rst_i  (RST),
    .push_i (inflight_q),
    .data_i (f_din),
    .pop_i  (pop),
    .data_o (f_head),
    .full_o (f_full),
    .empty_o(f_empty),
    .cnt_o  (f_cnt)
  );
  assign start_acc = state_q == IDLE && start;
  assign in_valid  = state_q == PUSH && !f_empty;
  assign pop       = in_valid && in_ready;
  // A beat leaving this cycle frees its slot, so the credit allows back-to-back beats.
  assign credit    = {1'b0, f_cnt} + {2'b0, inflight_q};
  assign issue     = state_q == PUSH && rd_cnt_q < P_TOT && !f_full && credit < ({2'b0, pop} + 3'd2);
  assign addr      = AW'(beat_addr(int'(rd_cnt_q), N, CH));
  assign wr        = out_ready && out_valid;
  assign last_wr   = wr && wr_cnt_q == Q_LAST;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start ? PUSH : IDLE;
      PUSH:    state_d = (pop && acc_cnt_q == P_LAST) ? WAIT : PUSH;
      WAIT:    state_d = wr ? (last_wr ? DONE : POP) : WAIT;
      POP:     state_d = last_wr ? DONE : POP;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    busy      = state_q == PUSH || state_q == WAIT || state_q == POP;
    done      = state_q == DONE;
    out_ready = state_q == WAIT || state_q == POP;
    a_rd_en   = issue;
    b_rd_en   = issue;
    a_rd_addr = issue ? addr : '0;
    b_rd_addr = issue ? addr : '0;
    in_stream = in_valid ? f_head : '0;
    c_wr_en   = wr;
    c_wr_addr = wr ? wr_cnt_q : '0;
    c_wr_data = wr ? out_stream : '0;
    cycles    = cycles_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      acc_cnt_q  <= '0;
      wr_cnt_q   <= '0;
      inflight_q <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= issue;
      rd_cnt_q   <= start_acc ? '0 : rd_cnt_q + rcnt_t'(issue);
      acc_cnt_q  <= start_acc ? '0 : acc_cnt_q + rcnt_t'(pop);
      wr_cnt_q   <= start_acc ? '0 : wr_cnt_q + CW'(wr);
      cycles_q   <= start_acc ? '0 : cycles_q + 32'(busy);
    end
  end
`ifdef SA_SCHED_STALL_CNT_EN
  logic [31:0] stall_q;
  logic stall;
  assign stall = (state_q == PUSH && in_valid && !in_ready) || (state_q == POP && !out_valid);
  assign stall_cycles = stall_q;
  always_ff @(posedge CLK) begin
    if (RST) stall_q <= '0;
    else stall_q <= start_acc ? '0 : stall_q + 32'(stall);
  end
`endif
endmodule

// File: tb/tb_sa_stream_sched.sv
// tb_sa_stream_sched: scoreboard bench for sa_stream_sched with BW=8, M=N=K=4 (one chunk per column).
module tb_sa_stream_sched;
  localparam int BW = 8, W = 32, LW = BW * W, HW = LW / 2;
  logic CLK = 1'b0, RST = 1'b1, start = 1'b0, in_ready = 1'b1, out_valid = 1'b0;
  logic [HW-1:0] a_rd_data, b_rd_data;
  logic [LW-1:0] out_stream = '0;
  logic busy, done, a_rd_en, b_rd_en, in_valid, out_ready, c_wr_en;
  logic [1:0] a_rd_addr, b_rd_addr;
  logic [0:0] c_wr_addr;
  logic [LW-1:0] in_stream, c_wr_data;
  logic [31:0] cycles;
`ifdef SA_SCHED_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif
  int total = 0, bad = 0;
  logic [HW-1:0] a_mem [4], b_mem [4];
  logic [LW-1:0] exp_in_q [$];
  logic [1:0] exp_addr_q [$];
  logic [LW-1:0] exp_c_data_q [$];
  logic [0:0] exp_c_addr_q [$];
  int beats_seen = 0, done_cnt = 0, busy_cnt = 0;
  logic held = 1'b0;
  logic [LW-1:0] held_data = '0;
  // Expected input beats, lane order 0..7, for beats p = 0..3 (n = 3,2,1,0).
  int tab [4][8] = '{'{4, 13, 8, 14, 12, 15, 16, 16},
                     '{3, 9, 7, 10, 11, 11, 15, 12},
                     '{2, 5, 6, 6, 10, 7, 14, 8},
                     '{1, 1, 5, 2, 9, 3, 13, 4}};

  sa_stream_sched dut (
    .CLK(CLK), .RST(RST), .start(start), .busy(busy), .done(done),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .in_stream(in_stream), .in_valid(in_valid), .in_ready(in_ready),
    .out_stream(out_stream), .out_valid(out_valid), .out_ready(out_ready),
    .c_wr_en(c_wr_en), .c_wr_addr(c_wr_addr), .c_wr_data(c_wr_data),
    .cycles(cycles)
`ifdef SA_SCHED_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
  end

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] beat(input int p);
    beat = '0;
    for (int l = 0; l < 8; l++) beat[l*W +: W] = tab[p][l];
  endfunction

  always @(negedge CLK) begin
    if (!RST) begin
      if (a_rd_en) begin
        if (exp_addr_q.size() == 0) chk("rd_unexpected", 1, 0);
        else begin
          logic [1:0] e;
          e = exp_addr_q.pop_front();
          chk("a_rd_addr", a_rd_addr, e);
          chk("b_rd", {b_rd_en, b_rd_addr}, {1'b1, e});
        end
      end
      if (held) begin
        chk("hold_valid", in_valid, 1);
        chk("hold_data", in_stream, held_data);
      end
      if (in_valid && in_ready) begin
        if (exp_in_q.size() == 0) chk("beat_unexpected", 1, 0);
        else chk("in_stream", in_stream, exp_in_q.pop_front());
        beats_seen++;
      end
      held = in_valid && !in_ready;
      held_data = in_stream;
      if (c_wr_en) begin
        chk("c_wr_vs_stream", c_wr_data, out_stream);
        if (exp_c_data_q.size() == 0) chk("c_wr_unexpected", 1, 0);
        else begin
          chk("c_wr_addr", c_wr_addr, exp_c_addr_q.pop_front());
          chk("c_wr_data", c_wr_data, exp_c_data_q.pop_front());
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        chk("cycles_vs_busy", cycles, busy_cnt);
      end
    end
  end

  task automatic load_exp();
    for (int p = 0; p < 4; p++) begin
      exp_addr_q.push_back(2'(3 - p));
      exp_in_q.push_back(beat(p));
    end
  endtask

  task automatic chk_zero(input string name);
    chk(name, {a_rd_en, b_rd_en, a_rd_addr, b_rd_addr, in_valid, out_ready, c_wr_en, c_wr_addr, busy, done, cycles}, 0);
    chk({name, "_data"}, in_stream | c_wr_data, 0);
  endtask

  task automatic run_job(input logic [15:0] pat, input bit gap, input bit hold, input int exp_cyc, input int exp_stall);
    int k, t, d0;
    logic [31:0] cyc_done;
    logic [LW-1:0] d;
    k = 0;
    d0 = done_cnt;
    load_exp();
    beats_seen = 0;
    busy_cnt = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    if (!hold) start = 1'b0;
    chk("busy_after_start", busy, 1);
    t = 0;
    while (beats_seen < 4 && t < 50) begin
      in_ready = in_valid ? pat[k] : 1'b1;
      if (in_valid) k++;
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 50) chk("push_timeout", beats_seen, 4);
    in_ready = 1'b1;
    for (int q = 0; q < 2; q++) begin
      if (gap && q > 0) begin
        out_valid = 1'b0;
        @(posedge CLK); #1;
      end
      for (int l = 0; l < 8; l++) d[l*W +: W] = 32'hC000_0000 + 32'(q * 256 + l);
      out_stream = d;
      exp_c_addr_q.push_back(1'(q));
      exp_c_data_q.push_back(d);
      out_valid = 1'b1;
      @(posedge CLK); #1;
    end
    out_valid = 1'b0;
    t = 0;
    while (!done && t < 20) begin
      @(posedge CLK); #1;
      t++;
    end
    if (!done) chk("done_timeout", done, 1);
    chk("busy_in_done", busy, 0);
    if (exp_cyc > 0) chk("cycles_hand", cycles, exp_cyc);
`ifdef SA_SCHED_STALL_CNT_EN
    chk("stall_cycles", stall_cycles, exp_stall);
`endif
    cyc_done = cycles;
    @(posedge CLK); #1;
    start = 1'b0;
    chk("done_pulse_once", {busy, done}, 0);
    chk("done_count_job", done_cnt, d0 + 1);
    chk("cycles_stable", cycles, cyc_done);
    @(posedge CLK); #1;
    chk("no_restart", busy, 0);
    $display("job finished: cycles=%0d expected_stall=%0d", cyc_done, exp_stall);
  endtask

  initial begin
    int t;
    for (int e = 0; e < 4; e++)
      for (int i = 0; i < 4; i++) begin
        a_mem[e][i*W +: W] = 32'(4 * i + e + 1);
        b_mem[e][i*W +: W] = 32'(4 * e + i + 1);
      end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk_zero("reset_outs");
    @(posedge CLK); #1;
    RST = 1'b0;
    out_valid = 1'b1;
    out_stream = {8{32'hDEAD_BEEF}};
    @(negedge CLK);
    chk("idle_out_ignored", {out_ready, c_wr_en, busy}, 0);
    @(posedge CLK); #1;
    out_valid = 1'b0;
    run_job(16'hFFFF, 1'b0, 1'b0, 8, 0);
    run_job(16'hFFF9, 1'b0, 1'b0, 0, 2);
    run_job(16'hFFFF, 1'b1, 1'b0, 0, 1);
    run_job(16'hFFFF, 1'b0, 1'b1, 0, 0);
    load_exp();
    beats_seen = 0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    t = 0;
    while (beats_seen < 2 && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 50) chk("abort_timeout", beats_seen, 2);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_zero("abort_outs");
    exp_in_q.delete();
    exp_addr_q.delete();
    run_job(16'hFFFF, 1'b0, 1'b0, 8, 0);
    chk("done_total", done_cnt, 5);
    chk("queues_drained", exp_in_q.size() + exp_addr_q.size() + exp_c_data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
